// File: rtl/serial_adder_subtractor_if.sv
// Request/response bundle for serial_adder_subtractor: operand handshake in, result and flags out.
// The requester drives through master; the arithmetic unit sits on slave.
interface serial_adder_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             signed_overflow;
  logic             unsigned_overflow;
  logic             zero_flag;
  logic             negative_flag;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, signed_overflow,
           unsigned_overflow, zero_flag, negative_flag
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, signed_overflow,
           unsigned_overflow, zero_flag, negative_flag
  );
endinterface

// File: rtl/serial_adder_subtractor.sv
// Digit-serial A+B / A-B, DIGIT_W bits per clock LSB first, result and flags on a valid/ready port.
// Optional macro SERIAL_ADDSUB_SAT_EN: saturate the result on signed overflow instead of wrapping.
module serial_adder_subtractor #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input logic                     clk,
  input logic                     rst,
  serial_adder_subtractor_if.slave bus
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [WIDTH-1:0]         a_r;
  logic [WIDTH-1:0]         b_r;
  logic [WIDTH-1:0]         acc_r;
  logic [WIDTH-1:0]         result_r;
  logic                     carry_r;
  logic                     sub_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     carry_out_r;
  logic                     signed_ovf_r;
  logic                     unsigned_ovf_r;
  logic                     zero_r;
  logic                     negative_r;

  logic [DIGIT_W-1:0]       digit_sum_s;
  logic                     digit_cout_s;
  logic                     digit_cmsb_s;
  logic [WIDTH+DIGIT_W-1:0] shift_cat_s;
  logic [WIDTH-1:0]         final_raw_s;
  logic [WIDTH-1:0]         final_res_s;
  logic                     sovf_s;
  logic                     last_digit_s;

`ifdef SERIAL_ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic a_sign);
    sat_value = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // Ripple add of the current digit; also keeps the carry into the digit's top bit,
  // which on the last digit is the carry into the word MSB.
  always_comb begin
    logic c_v;
    c_v          = carry_r;
    digit_sum_s  = {DIGIT_W{1'b0}};
    digit_cmsb_s = 1'b0;
    for (int i = 0; i < DIGIT_W; i++) begin
      digit_sum_s[i] = a_r[i] ^ b_r[i] ^ c_v;
      digit_cmsb_s   = c_v;
      c_v            = (a_r[i] & b_r[i]) | (c_v & (a_r[i] ^ b_r[i]));
    end
    digit_cout_s = c_v;
  end

  // Shift the new digit in from the MSB side and form the final (optionally saturated) word.
  always_comb begin
    shift_cat_s  = {digit_sum_s, acc_r};
    final_raw_s  = shift_cat_s[WIDTH+DIGIT_W-1:DIGIT_W];
    sovf_s       = digit_cmsb_s ^ digit_cout_s;
    last_digit_s = (cnt_r == CNT_W'(N - 1));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (sovf_s) begin
      final_res_s = sat_value(a_r[DIGIT_W-1]);
    end else begin
      final_res_s = final_raw_s;
    end
`else
    final_res_s = final_raw_s;
`endif
  end

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_digit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand shifters, carry, digit counter and the result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r            <= {WIDTH{1'b0}};
      b_r            <= {WIDTH{1'b0}};
      acc_r          <= {WIDTH{1'b0}};
      result_r       <= {WIDTH{1'b0}};
      carry_r        <= 1'b0;
      sub_r          <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      carry_out_r    <= 1'b0;
      signed_ovf_r   <= 1'b0;
      unsigned_ovf_r <= 1'b0;
      zero_r         <= 1'b0;
      negative_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtraction as A + ~B + 1: the +1 enters through the initial carry.
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            sub_r   <= bus.sub;
            carry_r <= bus.sub;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT_W;
          b_r     <= b_r >> DIGIT_W;
          acc_r   <= final_raw_s;
          carry_r <= digit_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_digit_s) begin
            result_r       <= final_res_s;
            carry_out_r    <= digit_cout_s;
            signed_ovf_r   <= sovf_s;
            unsigned_ovf_r <= sub_r ? ~digit_cout_s : digit_cout_s;
            zero_r         <= (final_res_s == {WIDTH{1'b0}});
            negative_r     <= final_res_s[WIDTH-1];
          end else begin
            result_r <= result_r;
          end
        end
        DONE:    cnt_r <= cnt_r;
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign bus.in_ready          = (state_r == IDLE);
  assign bus.out_valid         = (state_r == DONE);
  assign bus.result            = result_r;
  assign bus.carry_out         = carry_out_r;
  assign bus.signed_overflow   = signed_ovf_r;
  assign bus.unsigned_overflow = unsigned_ovf_r;
  assign bus.zero_flag         = zero_r;
  assign bus.negative_flag     = negative_r;
endmodule
